// File: rtl/uart_rx_bit_sampler.sv
// Mid-bit majority sampler and frame checker for the UART receive path.
// Consumes bit/edge counts from the edge/bit counter and emits words plus error pulses.
module uart_rx_bit_sampler #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rx_in,
  input  logic [3:0]            bit_cnt,
  input  logic [2:0]            edge_cnt,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  sampled_bit,
  output logic                  sample_strobe,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_WIDTH);
  localparam logic [3:0] PAR_IDX       = 4'(DATA_WIDTH + 1);
  localparam logic [3:0] STP_IDX_PAR   = 4'(DATA_WIDTH + 2);

  typedef enum logic [1:0] {
    FRAME_OK   = 2'd0,
    FRAME_BAD  = 2'd1,
    FRAME_SKIP = 2'd2
  } frame_state_e;

  frame_state_e          frame_q, frame_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_strobe_q, sample_strobe_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic [3:0]            stop_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q         <= FRAME_OK;
      s0_q            <= 1'b0;
      s1_q            <= 1'b0;
      sampled_bit_q   <= 1'b0;
      sample_strobe_q <= 1'b0;
      shift_q         <= '0;
      par_acc_q       <= 1'b0;
      par_en_q        <= 1'b0;
      par_typ_q       <= 1'b0;
      p_data_q        <= '0;
      data_valid_q    <= 1'b0;
      strt_glitch_q   <= 1'b0;
      par_err_q       <= 1'b0;
      stp_err_q       <= 1'b0;
    end else begin
      frame_q         <= frame_d;
      s0_q            <= s0_d;
      s1_q            <= s1_d;
      sampled_bit_q   <= sampled_bit_d;
      sample_strobe_q <= sample_strobe_d;
      shift_q         <= shift_d;
      par_acc_q       <= par_acc_d;
      par_en_q        <= par_en_d;
      par_typ_q       <= par_typ_d;
      p_data_q        <= p_data_d;
      data_valid_q    <= data_valid_d;
      strt_glitch_q   <= strt_glitch_d;
      par_err_q       <= par_err_d;
      stp_err_q       <= stp_err_d;
    end
  end

  always_comb begin
    frame_d         = frame_q;
    s0_d            = s0_q;
    s1_d            = s1_q;
    sampled_bit_d   = sampled_bit_q;
    sample_strobe_d = 1'b0;
    shift_d         = shift_q;
    par_acc_d       = par_acc_q;
    par_en_d        = par_en_q;
    par_typ_d       = par_typ_q;
    p_data_d        = p_data_q;
    data_valid_d    = 1'b0;
    strt_glitch_d   = 1'b0;
    par_err_d       = 1'b0;
    stp_err_d       = 1'b0;
    stop_idx        = par_en_q ? STP_IDX_PAR : PAR_IDX;

    if (enable) begin
      if (edge_cnt == 3'd3) s0_d = rx_in;
      if (edge_cnt == 3'd4) s1_d = rx_in;
      if (edge_cnt == 3'd5) begin
        sampled_bit_d   = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
        sample_strobe_d = 1'b1;
      end
    end else begin
      s0_d = 1'b0;
      s1_d = 1'b0;
    end

    // The role action runs off the registered strobe, so it still completes if enable drops now.
    if (sample_strobe_q && frame_q != FRAME_SKIP) begin
      if (bit_cnt == 4'd0) begin
        par_en_d      = par_en;
        par_typ_d     = par_typ;
        shift_d       = '0;
        par_acc_d     = 1'b0;
        frame_d       = sampled_bit_q ? FRAME_SKIP : FRAME_OK;
        strt_glitch_d = sampled_bit_q;
      end else if (bit_cnt <= LAST_DATA_IDX) begin
        shift_d   = {sampled_bit_q, shift_q[DATA_WIDTH-1:1]};
        par_acc_d = par_acc_q ^ sampled_bit_q;
      end else if (bit_cnt == PAR_IDX && par_en_q) begin
        if ((par_acc_q ^ par_typ_q) != sampled_bit_q) begin
          par_err_d = 1'b1;
          frame_d   = FRAME_BAD;
        end
      end else if (bit_cnt == stop_idx) begin
        if (!sampled_bit_q) begin
          stp_err_d = 1'b1;
        end else if (frame_q == FRAME_OK) begin
          p_data_d     = shift_q;
          data_valid_d = 1'b1;
        end
      end
    end

    if (!enable) begin
      frame_d   = FRAME_OK;
      shift_d   = '0;
      par_acc_d = 1'b0;
    end
  end

  assign sampled_bit   = sampled_bit_q;
  assign sample_strobe = sample_strobe_q;
  assign p_data        = p_data_q;
  assign data_valid    = data_valid_q;
  assign strt_glitch   = strt_glitch_q;
  assign par_err       = par_err_q;
  assign stp_err       = stp_err_q;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed bench for uart_rx_bit_sampler: drives bit/edge counts and the serial line
// frame by frame and checks pulse counts, pulse positions and received words.
module tb_uart_rx_bit_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       rx_in;
  logic [3:0] bit_cnt;
  logic [2:0] edge_cnt;
  logic       par_en;
  logic       par_typ;
  logic       sampled_bit;
  logic       sample_strobe;
  logic [7:0] p_data;
  logic       data_valid;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;

  int checks = 0;
  int errors = 0;

  int         n_valid, n_par, n_stp, n_glitch, n_strobe;
  logic [6:0] pos_valid, pos_par, pos_stp, pos_glitch, pos_strobe_first;

  uart_rx_bit_sampler #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .rx_in         (rx_in),
    .bit_cnt       (bit_cnt),
    .edge_cnt      (edge_cnt),
    .par_en        (par_en),
    .par_typ       (par_typ),
    .sampled_bit   (sampled_bit),
    .sample_strobe (sample_strobe),
    .p_data        (p_data),
    .data_valid    (data_valid),
    .strt_glitch   (strt_glitch),
    .par_err       (par_err),
    .stp_err       (stp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are registered, so at the falling edge they show this cycle's values.
  task automatic observe(input logic [6:0] pos);
    if (data_valid)  begin n_valid++;  pos_valid  = pos; end
    if (par_err)     begin n_par++;    pos_par    = pos; end
    if (stp_err)     begin n_stp++;    pos_stp    = pos; end
    if (strt_glitch) begin n_glitch++; pos_glitch = pos; end
    if (sample_strobe) begin
      if (n_strobe == 0) pos_strobe_first = pos;
      n_strobe++;
    end
  endtask

  task automatic driveIdle();
    enable   = 1'b0;
    rst      = 1'b0;
    rx_in    = 1'b1;
    bit_cnt  = 4'd0;
    edge_cnt = 3'd0;
  endtask

  // bits[b] is the line level of bit index b; gmask inverts rx_in on chosen edges of bit gbit.
  // par_en/par_typ are inverted after the start bit to show only the latched values matter.
  task automatic applyStimulus(input logic [11:0] bits, input int nbits, input logic pe,
                               input logic pt, input int gbit, input logic [7:0] gmask,
                               input int abort_bit, input int abort_edge,
                               input int rst_bit, input int rst_edge);
    logic stop_now;
    n_valid = 0; n_par = 0; n_stp = 0; n_glitch = 0; n_strobe = 0;
    pos_valid = '0; pos_par = '0; pos_stp = '0; pos_glitch = '0; pos_strobe_first = '0;
    stop_now = 1'b0;
    for (int b = 0; b < nbits && !stop_now; b++) begin
      for (int e = 0; e < 8 && !stop_now; e++) begin
        @(negedge clk);
        if (b == abort_bit && e == abort_edge) begin
          stop_now = 1'b1;
          driveIdle();
        end else begin
          enable   = 1'b1;
          bit_cnt  = 4'(b);
          edge_cnt = 3'(e);
          par_en   = (b == 0) ? pe : ~pe;
          par_typ  = (b == 0) ? pt : ~pt;
          rx_in    = bits[b] ^ ((b == gbit) ? gmask[e] : 1'b0);
          rst      = (b == rst_bit && e == rst_edge);
        end
        observe({4'(b), 3'(e)});
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      driveIdle();
      observe(7'h7f);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; rx_in = 1'b1; bit_cnt = 4'd0; edge_cnt = 3'd0;
    par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_sampled_bit", 32'(sampled_bit), 32'h0);
    checkOutput("rst_strobe",      32'(sample_strobe), 32'h0);
    checkOutput("rst_p_data",      32'(p_data), 32'h0);
    checkOutput("rst_valid",       32'(data_valid), 32'h0);
    checkOutput("rst_glitch",      32'(strt_glitch), 32'h0);
    checkOutput("rst_par_err",     32'(par_err), 32'h0);
    checkOutput("rst_stp_err",     32'(stp_err), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] 8N1 frame 0xA5");
    applyStimulus({2'b11, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b0, -1, 8'h00, -1, -1, -1, -1);
    checkOutput("a5_p_data",       32'(p_data), 32'hA5);
    checkOutput("a5_valid_cnt",    32'(n_valid), 32'd1);
    checkOutput("a5_valid_pos",    32'(pos_valid), 32'h4F);
    checkOutput("a5_err_cnt",      32'(n_par + n_stp + n_glitch), 32'd0);
    checkOutput("a5_strobe_cnt",   32'(n_strobe), 32'd10);
    checkOutput("a5_strobe_first", 32'(pos_strobe_first), 32'h06);

    $display("[TB] even parity 0x3C good parity");
    applyStimulus({1'b1, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1'b1, 1'b0, -1, 8'h00, -1, -1, -1, -1);
    checkOutput("ev_good_p_data",    32'(p_data), 32'h3C);
    checkOutput("ev_good_valid_cnt", 32'(n_valid), 32'd1);
    checkOutput("ev_good_valid_pos", 32'(pos_valid), 32'h57);
    checkOutput("ev_good_err_cnt",   32'(n_par + n_stp + n_glitch), 32'd0);

    $display("[TB] even parity 0x3C bad parity");
    applyStimulus({1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 1'b1, 1'b0, -1, 8'h00, -1, -1, -1, -1);
    checkOutput("ev_bad_par_cnt",   32'(n_par), 32'd1);
    checkOutput("ev_bad_par_pos",   32'(pos_par), 32'h4F);
    checkOutput("ev_bad_valid_cnt", 32'(n_valid), 32'd0);
    checkOutput("ev_bad_stp_cnt",   32'(n_stp), 32'd0);
    checkOutput("ev_bad_p_data",    32'(p_data), 32'h3C);

    $display("[TB] odd parity 0x01 good parity");
    applyStimulus({1'b1, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 1'b1, 1'b1, -1, 8'h00, -1, -1, -1, -1);
    checkOutput("odd_p_data",    32'(p_data), 32'h01);
    checkOutput("odd_valid_cnt", 32'(n_valid), 32'd1);
    checkOutput("odd_err_cnt",   32'(n_par + n_stp + n_glitch), 32'd0);

    $display("[TB] odd parity 0x01 stop bit low");
    applyStimulus({1'b1, 1'b0, 1'b0, 8'h01, 1'b0}, 11, 1'b1, 1'b1, -1, 8'h00, -1, -1, -1, -1);
    checkOutput("stp_cnt",       32'(n_stp), 32'd1);
    checkOutput("stp_pos",       32'(pos_stp), 32'h57);
    checkOutput("stp_valid_cnt", 32'(n_valid), 32'd0);
    checkOutput("stp_par_cnt",   32'(n_par), 32'd0);
    checkOutput("stp_p_data",    32'(p_data), 32'h01);

    $display("[TB] start bit voted high");
    applyStimulus({2'b11, 1'b1, 8'hFF, 1'b0}, 10, 1'b0, 1'b0, 0, 8'b0010_1000, -1, -1, -1, -1);
    checkOutput("glitch_cnt",       32'(n_glitch), 32'd1);
    checkOutput("glitch_pos",       32'(pos_glitch), 32'h07);
    checkOutput("glitch_valid_cnt", 32'(n_valid), 32'd0);
    checkOutput("glitch_stp_cnt",   32'(n_stp), 32'd0);
    checkOutput("glitch_p_data",    32'(p_data), 32'h01);

    $display("[TB] single-edge glitch on data bit 4");
    applyStimulus({2'b11, 1'b1, 8'h00, 1'b0}, 10, 1'b0, 1'b0, 4, 8'b0001_0000, -1, -1, -1, -1);
    checkOutput("spike_p_data",    32'(p_data), 32'h00);
    checkOutput("spike_valid_cnt", 32'(n_valid), 32'd1);
    checkOutput("spike_err_cnt",   32'(n_par + n_stp + n_glitch), 32'd0);

    $display("[TB] enable dropped mid-data then frame 0x5A");
    applyStimulus({2'b11, 1'b1, 8'hFF, 1'b0}, 10, 1'b0, 1'b0, -1, 8'h00, 4, 2, -1, -1);
    checkOutput("abort_valid_cnt", 32'(n_valid), 32'd0);
    checkOutput("abort_err_cnt",   32'(n_par + n_stp + n_glitch), 32'd0);
    applyStimulus({2'b11, 1'b1, 8'h5A, 1'b0}, 10, 1'b0, 1'b0, -1, 8'h00, -1, -1, -1, -1);
    checkOutput("5a_p_data",    32'(p_data), 32'h5A);
    checkOutput("5a_valid_cnt", 32'(n_valid), 32'd1);
    checkOutput("5a_valid_pos", 32'(pos_valid), 32'h4F);

    $display("[TB] reset on stop bit strobe cycle");
    applyStimulus({2'b11, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, 1'b0, -1, 8'h00, -1, -1, 9, 6);
    checkOutput("rstmid_valid_cnt",   32'(n_valid), 32'd0);
    checkOutput("rstmid_err_cnt",     32'(n_par + n_stp + n_glitch), 32'd0);
    checkOutput("rstmid_p_data",      32'(p_data), 32'h00);
    checkOutput("rstmid_sampled_bit", 32'(sampled_bit), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_sampler.md
# uart_rx_bit_sampler

Oversampling data sampler and frame checker for the UART receive path. It sits directly downstream of the edge/bit counter: it consumes the counter's `bit_cnt`/`edge_cnt` (8 edges per bit) and the raw serial line, takes a majority vote at mid-bit, and shifts data bits into a parallel word. It flags start-glitch, parity and stop errors for the RX FSM, and presents completed words with a one-cycle valid pulse.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; must be 5..8 so bit index fits in 4 bits.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high; one clock; reset is synchronous and active-high.
- `enable` input 1: frame active; same enable the RX FSM drives into the edge/bit counter.
- `rx_in` input 1: serial line; idle high; treated as already synchronised.
- `bit_cnt` input 4: current bit index (0 = start) from the edge/bit counter.
- `edge_cnt` input 3: current oversample edge 0..7 from the edge/bit counter.
- `par_en` input 1: 1 = frame carries a parity bit.
- `par_typ` input 1: 0 = even, 1 = odd.
- `sampled_bit` output 1: last majority-voted bit.
- `sample_strobe` output 1: one-cycle pulse; `sampled_bit` is new this cycle.
- `p_data` output DATA_WIDTH: last successfully received word, LSB first on line.
- `data_valid` output 1: one-cycle pulse; `p_data` updated with a good frame.
- `strt_glitch` output 1: one-cycle pulse; start bit voted 1.
- `par_err` output 1: one-cycle pulse; parity mismatch.
- `stp_err` output 1: one-cycle pulse; stop bit voted 0.

## Operation
- Reset: all outputs 0; shift register, parity accumulator, sample regs, latched par_en/par_typ cleared.
- Sampling, only while `enable`=1: capture `rx_in` into s0 at edge_cnt 3 and into s1 at edge_cnt 4. At edge_cnt 5, register `sampled_bit` <= majority(s0, s1, rx_in) and set `sample_strobe`=1 for the next cycle only.
- Bit role from `bit_cnt` at strobe: 0 = start; 1..DATA_WIDTH = data; DATA_WIDTH+1 = parity if latched par_en, else stop; DATA_WIDTH+2 = stop if latched par_en. Any higher index is ignored, with no action and no error.
- Start (strobe cycle): latch `par_en`/`par_typ` for the frame; clear shift reg and parity accumulator. If sampled_bit=1, pulse `strt_glitch` and ignore the remaining strobes until `enable` falls.
- Data: shift right, inserting sampled_bit at MSB (first data bit ends in LSB after DATA_WIDTH shifts). XOR into the parity accumulator.
- Parity: expected = accumulator XOR par_typ. On mismatch, pulse `par_err` and mark the frame bad.
- Stop: if sampled_bit=0, pulse `stp_err`. If sampled_bit=1 and the frame is not bad, load `p_data` from the shift reg and pulse `data_valid`.
- `enable`=0: s0/s1 cleared, no strobe, frame state cleared. `p_data` holds its last value.
- par_en/par_typ changes mid-frame are ignored; only the values latched at the start strobe apply.
- At most one of data_valid/par_err/stp_err/strt_glitch pulses per cycle. `stp_err` and a prior `par_err` on the same frame may both occur, on different cycles.

## Timing
- Vote registered on the edge_cnt=5 cycle. `sampled_bit`/`sample_strobe` are visible while edge_cnt=6.
- Role actions are registered on the strobe cycle. Flags and `p_data` are visible while edge_cnt=7 of the same bit, two cycles after the edge_cnt=5 sample.
- `data_valid` therefore rises at edge_cnt=7 of the stop bit and is high exactly one cycle.
- `rst` overrides everything in the same cycle, including a pending strobe or flag.
- `enable` falling on the cycle after a strobe still allows that strobe's action to complete. Falling earlier discards the pending vote.
- Back-to-back frames with `enable` held high are supported. A new start strobe re-initialises the frame state.

## Test plan
- 8N1, DATA_WIDTH=8, par_en=0, send 0xA5 (line bits 1,0,1,0,0,1,0,1 LSB first) with a stop bit of 1 -> `p_data`=0xA5, single `data_valid` pulse at stop bit edge_cnt=7, no error flags.
- Even parity, send 0x3C with parity bit 0 -> `data_valid` and `p_data`=0x3C. Repeat with parity bit 1 -> `par_err` pulse at the parity bit edge_cnt=7, no `data_valid`, `p_data` unchanged.
- Odd parity, send 0x01 with parity 0 -> valid. Stop bit forced 0 -> `stp_err` pulse, no `data_valid`.
- Start bit with rx_in=1 at edges 3 and 5 -> `strt_glitch` pulse, no later strobe actions. Single-edge glitch (rx_in=1 only at edge 4) on a data bit -> voted bit is correct, 0x00 received.
- Drop `enable` mid-data (bit 4, edge 2), then a new full frame 0x5A -> only 0x5A reported, no stale bits.
- Assert `rst` on the stop bit strobe cycle -> all outputs 0 next cycle, no `data_valid`.
